codestream_out_packer: RTL and testbench
========================================

Name: codestream_out_packer

Overview:
Parametrised successor to the single-stream Tier-2 output stage. It merges NUM_CH per-component byte streams into OUT_BYTES-wide words with byte-lane write enables and an incrementing output address. A byte budget derived from compression_ratio truncates the stream at an exact byte. It sits between the per-component Tier-2 engines and the external codestream memory.

Parameters:
NUM_CH, 3, number of input channels (components); must be >= 1
IN_BYTES, 2, bytes per input beat; must be <= OUT_BYTES
OUT_BYTES, 4, bytes per output word
ADDR_W, 32, output address width
BASE_ADDR, 0, address of the first output word
BUDGET_UNIT, 4096, byte-budget granule

Ports:
clk_dwt  in  1  single clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse: begin a new codestream (honoured only in IDLE)
compression_ratio  in  3  budget select, sampled on start
in_data  in  NUM_CH*IN_BYTES*8  per-channel beat; channel c occupies slice c; first byte in the MS lane
in_nbytes  in  NUM_CH*$clog2(IN_BYTES+1)  valid bytes in the beat (0..IN_BYTES), taken from the MS lanes
in_valid  in  NUM_CH  beat present
in_last  in  NUM_CH  final beat of that channel's segment
in_ready  out  NUM_CH  beat accepted when valid&&ready
output_to_fpga_32  out  OUT_BYTES*8  packed word; byte 0 in the MS lane
write_en  out  OUT_BYTES  lane enables; bit OUT_BYTES-1 = byte 0; nonzero only on a write cycle
output_address  out  ADDR_W  byte address of the current word
byte_count  out  32  bytes committed so far
budget_hit  out  1  sticky; budget reached
done  out  1  one-cycle pulse at stream end

Behaviour:
- Reset: state IDLE; all outputs 0; output_address=BASE_ADDR; accumulator, finished-mask and grant cleared. Reset mid-stream abandons it and emits no partial word.
- Budget: compression_ratio==0 means unlimited; k=1..7 gives budget=BUDGET_UNIT<<(7-k) bytes. Latched on start.
- States:
  - IDLE: start -> RUN; clears byte_count, budget_hit and finished-mask; output_address=BASE_ADDR; grant=channel 0.
  - RUN: only the granted channel has in_ready=1; the others have 0. When the granted channel's beat with in_last is accepted, it is marked finished and grant moves to the next higher unfinished channel. When all channels are finished -> FLUSH.
  - FLUSH: if the accumulator holds 1..OUT_BYTES-1 bytes, emit one partial word with zeros in the unused low lanes and write_en set on the leading lanes only (e.g. 3 bytes -> 4'b1110). If the accumulator is empty, emit nothing. -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- Packing:
  - The accumulator holds up to OUT_BYTES+IN_BYTES-1 bytes in arrival order.
  - Each cycle, accepted bytes are appended. If the fill is >= OUT_BYTES, the oldest OUT_BYTES bytes are written out on the next edge with write_en all ones.
  - in_ready in RUN therefore never stalls: throughput is one beat per cycle.
  - Latency: the word is visible one cycle after the beat that completes it.
- output_address holds the address of the word being written. It advances by OUT_BYTES after each write, wrapping mod 2^ADDR_W.
- byte_count counts kept bytes only and saturates at the budget.
- Budget truncation:
  - If a beat crosses the budget, only the bytes up to the budget are kept and the rest are discarded.
  - budget_hit rises the cycle after the crossing.
  - After that, beats are still accepted (ready unchanged) and dropped, so upstream drains; in_last still advances grant/FLUSH.
- in_nbytes==0 beat: accepted, appends nothing, in_last honoured. in_nbytes>IN_BYTES is clamped to IN_BYTES.
- in_valid on a non-granted or finished channel is ignored.
- start outside IDLE is ignored.

Test Plan:
- Defaults, cr=0. Ch0 sends 0x0102,0x0304(last); ch1 sends 0x0506(last); ch2 sends 0x07 with nbytes=1 (last). Required: words 0x01020304 @0 with we=1111, then 0x05060700 @4 with we=1110 (FLUSH), then done.
- Grant order: ch2 valid asserted first with ch0 still unfinished. Required: in_ready[2]=0 until ch0 and ch1 have sent their last beats; output carries all ch0 bytes before any ch1 byte.
- Budget: cr=7, BUDGET_UNIT=4, 5 full beats on ch0 (10 bytes). Required: exactly 4 bytes written (one word), byte_count=4, budget_hit=1, remaining beats acknowledged, done after the last beat of each channel.
- Crossing: BUDGET_UNIT=6, cr=7, three beats 0xAABB,0xCCDD,0xEEFF then 0x1122. Required: words 0xAABBCCDD and 0xEEFF0000 with we=1100; byte_count=6.
- Reset asserted after 3 words. Required: next cycle write_en=0, output_address=BASE_ADDR, byte_count=0, no flush word. A new start restarts the stream at address 0.
- Empty stream: start, then every channel sends one beat with nbytes=0 and last. Required: no write, done pulses exactly once, byte_count=0.

Source files
------------

// File: rtl/codestream_out_packer_if.sv
// Byte-stream ingress and packed-word egress of the codestream output packer.
// The slave side is the packer; the master side is its upstream/downstream environment.
interface codestream_out_packer_if #(
   parameter int unsigned NUM_CH    = 3,
   parameter int unsigned IN_BYTES  = 2,
   parameter int unsigned OUT_BYTES = 4,
   parameter int unsigned ADDR_W    = 32
);
   localparam int unsigned NB_W = $clog2(IN_BYTES + 1);

   logic [NUM_CH*IN_BYTES*8-1:0] in_data;
   logic [NUM_CH*NB_W-1:0]       in_nbytes;
   logic [NUM_CH-1:0]            in_valid;
   logic [NUM_CH-1:0]            in_last;
   logic [NUM_CH-1:0]            in_ready;
   logic [OUT_BYTES*8-1:0]       output_to_fpga_32;
   logic [OUT_BYTES-1:0]         write_en;
   logic [ADDR_W-1:0]            output_address;

   modport master (
      output in_data, in_nbytes, in_valid, in_last,
      input  in_ready, output_to_fpga_32, write_en, output_address
   );

   modport slave (
      input  in_data, in_nbytes, in_valid, in_last,
      output in_ready, output_to_fpga_32, write_en, output_address
   );
endinterface

// File: rtl/codestream_out_packer.sv
// Merges per-component Tier-2 byte streams, channel by channel, into wide memory words
// with lane enables, a running address and a byte budget that truncates the codestream.
module codestream_out_packer #(
   parameter int unsigned       NUM_CH      = 3,
   parameter int unsigned       IN_BYTES    = 2,
   parameter int unsigned       OUT_BYTES   = 4,
   parameter int unsigned       ADDR_W      = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
   parameter int unsigned       BUDGET_UNIT = 4096
) (
   input  logic                  clk_dwt,
   input  logic                  rst,
   input  logic                  start,
   input  logic [2:0]            compression_ratio,
   codestream_out_packer_if.slave bus,
   output logic [31:0]           byte_count,
   output logic                  budget_hit,
   output logic                  done
);
   localparam int unsigned NB_W      = $clog2(IN_BYTES + 1);
   localparam int unsigned ACC_BYTES = OUT_BYTES + IN_BYTES - 1;
   localparam int unsigned FILL_W    = $clog2(ACC_BYTES + 1);
   localparam int unsigned GNT_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

   state_e                 state_q, state_d;
   logic [GNT_W-1:0]       grant_q, grant_d, next_grant;
   logic [NUM_CH-1:0]      fin_q, fin_d, fin_set, gnt_onehot;
   logic [ACC_BYTES*8-1:0] acc_q, acc_d, acc_app;
   logic [FILL_W-1:0]      fill_q, fill_d, fill_app;
   logic                   limited_q, limited_d;
   logic [31:0]            budget_q, budget_d, remaining;
   logic [31:0]            byte_count_q, byte_count_d;
   logic                   budget_hit_q, budget_hit_d;
   logic [OUT_BYTES*8-1:0] word_q, word_d;
   logic [OUT_BYTES-1:0]   we_q, we_d, lead;
   logic [ADDR_W-1:0]      addr_q, addr_d;
   logic [IN_BYTES*8-1:0]  beat;
   logic [NB_W-1:0]        nb_raw, nb, keep;
   logic                   accept, found;

   assign gnt_onehot = NUM_CH'(1) << grant_q;
   assign accept     = (state_q == StRun) && bus.in_valid[grant_q];

   // Beat of the granted channel, clamped and cut down to what the budget still allows.
   always_comb begin
      beat   = bus.in_data[grant_q*(IN_BYTES*8) +: IN_BYTES*8];
      nb_raw = bus.in_nbytes[grant_q*NB_W +: NB_W];
      nb     = (nb_raw > NB_W'(IN_BYTES)) ? NB_W'(IN_BYTES) : nb_raw;
      remaining = budget_q - byte_count_q;
      keep   = nb;
      if (limited_q && (32'(nb) > remaining)) begin
         keep = NB_W'(remaining);
      end
   end

   // Accumulator byte p sits at the MS end for p=0; kept bytes land right after the fill.
   always_comb begin
      acc_app = acc_q;
      for (int p = 0; p < ACC_BYTES; p++) begin
         for (int j = 0; j < IN_BYTES; j++) begin
            if ((j < int'(keep)) && (p == int'(fill_q) + j)) begin
               acc_app[(ACC_BYTES-1-p)*8 +: 8] = beat[(IN_BYTES-1-j)*8 +: 8];
            end
         end
      end
      fill_app = fill_q + FILL_W'(keep);
   end

   always_comb begin
      fin_set    = fin_q | gnt_onehot;
      next_grant = grant_q;
      found      = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (!found && (c > int'(grant_q)) && !fin_set[c]) begin
            next_grant = GNT_W'(c);
            found      = 1'b1;
         end
      end
   end

   always_comb begin
      lead = '0;
      for (int l = 0; l < OUT_BYTES; l++) begin
         lead[OUT_BYTES-1-l] = (l < int'(fill_q));
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      fin_d        = fin_q;
      acc_d        = acc_q;
      fill_d       = fill_q;
      limited_d    = limited_q;
      budget_d     = budget_q;
      byte_count_d = byte_count_q;
      budget_hit_d = budget_hit_q;
      word_d       = word_q;
      we_d         = '0;
      addr_d       = addr_q;
      if (we_q != '0) begin
         addr_d = addr_q + ADDR_W'(OUT_BYTES);
      end
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d      = StRun;
               grant_d      = '0;
               fin_d        = '0;
               acc_d        = '0;
               fill_d       = '0;
               byte_count_d = '0;
               budget_hit_d = 1'b0;
               addr_d       = BASE_ADDR;
               limited_d    = (compression_ratio != 3'd0);
               budget_d     = 32'(BUDGET_UNIT) << (3'd7 - compression_ratio);
            end
         end
         StRun: begin
            if (accept) begin
               byte_count_d = byte_count_q + 32'(keep);
               if (limited_q && (byte_count_d >= budget_q)) begin
                  budget_hit_d = 1'b1;
               end
               if (fill_app >= FILL_W'(OUT_BYTES)) begin
                  word_d = acc_app[ACC_BYTES*8-1 -: OUT_BYTES*8];
                  we_d   = '1;
                  acc_d  = acc_app << (OUT_BYTES*8);
                  fill_d = fill_app - FILL_W'(OUT_BYTES);
               end else begin
                  acc_d  = acc_app;
                  fill_d = fill_app;
               end
               if (bus.in_last[grant_q]) begin
                  fin_d = fin_set;
                  if (&fin_set) begin
                     state_d = StFlush;
                  end else begin
                     grant_d = next_grant;
                  end
               end
            end
         end
         StFlush: begin
            // Residue is always shorter than a word, so at most one partial write.
            if (fill_q != '0) begin
               word_d = acc_q[ACC_BYTES*8-1 -: OUT_BYTES*8];
               we_d   = lead;
            end
            acc_d   = '0;
            fill_d  = '0;
            state_d = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_dwt) begin
      if (rst) begin
         state_q      <= StIdle;
         grant_q      <= '0;
         fin_q        <= '0;
         acc_q        <= '0;
         fill_q       <= '0;
         limited_q    <= 1'b0;
         budget_q     <= '0;
         byte_count_q <= '0;
         budget_hit_q <= 1'b0;
         word_q       <= '0;
         we_q         <= '0;
         addr_q       <= BASE_ADDR;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         fin_q        <= fin_d;
         acc_q        <= acc_d;
         fill_q       <= fill_d;
         limited_q    <= limited_d;
         budget_q     <= budget_d;
         byte_count_q <= byte_count_d;
         budget_hit_q <= budget_hit_d;
         word_q       <= word_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
      end
   end

   assign bus.in_ready          = (state_q == StRun) ? gnt_onehot : '0;
   assign bus.output_to_fpga_32 = word_q;
   assign bus.write_en          = we_q;
   assign bus.output_address    = addr_q;
   assign byte_count            = byte_count_q;
   assign budget_hit            = budget_hit_q;
   assign done                  = (state_q == StDone);
endmodule

// File: tb/tb_codestream_out_packer.sv
// Bench for codestream_out_packer: a byte-queue model predicts every write, a per-cycle
// compare process checks the DUTs against it, and directed streams pin literal results.
module tb_codestream_out_packer;
   localparam int unsigned NUM_CH = 3, IN_BYTES = 2, OUT_BYTES = 4, ADDR_W = 32;

   typedef struct {
      int          dut;
      logic [31:0] word;
      logic [3:0]  we;
      logic [31:0] addr;
   } wr_t;

   logic        clk_dwt = 1'b0;
   logic        rst;
   logic        start_a, start_b, sel_b, watch2;
   logic [2:0]  cr;
   logic [47:0] in_data;
   logic [5:0]  in_nbytes;
   logic [2:0]  in_valid, in_last, rdy;
   logic [31:0] byte_count_a, byte_count_b;
   logic        budget_hit_a, budget_hit_b, done_a, done_b;

   int n_checks = 0;
   int n_fail = 0;
   int done_cnt[2] = '{0, 0};
   wr_t exp_q[$];
   wr_t log_q[$];

   int          m_unit[2] = '{4, 6};
   logic        m_lim[2];
   longint      m_budget[2];
   int          m_count[2], m_np[2], m_fin[2];
   logic [31:0] m_word[2], m_addr[2];

   always #5 clk_dwt = ~clk_dwt;

   codestream_out_packer_if #(.NUM_CH(NUM_CH), .IN_BYTES(IN_BYTES), .OUT_BYTES(OUT_BYTES),
      .ADDR_W(ADDR_W)) bus_a ();
   codestream_out_packer_if #(.NUM_CH(NUM_CH), .IN_BYTES(IN_BYTES), .OUT_BYTES(OUT_BYTES),
      .ADDR_W(ADDR_W)) bus_b ();

   assign bus_a.in_data   = in_data;
   assign bus_a.in_nbytes = in_nbytes;
   assign bus_a.in_valid  = in_valid;
   assign bus_a.in_last   = in_last;
   assign bus_b.in_data   = in_data;
   assign bus_b.in_nbytes = in_nbytes;
   assign bus_b.in_valid  = in_valid;
   assign bus_b.in_last   = in_last;
   assign rdy = sel_b ? bus_b.in_ready : bus_a.in_ready;

   codestream_out_packer #(.BUDGET_UNIT(4)) dut_a (
      .clk_dwt(clk_dwt), .rst(rst), .start(start_a), .compression_ratio(cr), .bus(bus_a),
      .byte_count(byte_count_a), .budget_hit(budget_hit_a), .done(done_a)
   );

   codestream_out_packer #(.BUDGET_UNIT(6)) dut_b (
      .clk_dwt(clk_dwt), .rst(rst), .start(start_b), .compression_ratio(cr), .bus(bus_b),
      .byte_count(byte_count_b), .budget_hit(budget_hit_b), .done(done_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   // ---------------- model: byte queue per DUT, cut into words ----------------
   task automatic model_reset();
      exp_q.delete();
      for (int d = 0; d < 2; d++) begin
         m_lim[d] = 1'b0; m_budget[d] = 0; m_count[d] = 0; m_np[d] = 0;
         m_fin[d] = 0; m_word[d] = '0; m_addr[d] = '0;
      end
   endtask

   task automatic model_start(input int d, input logic [2:0] c);
      m_lim[d]    = (c != 3'd0);
      m_budget[d] = longint'(m_unit[d]) << (7 - int'(c));
      m_count[d]  = 0; m_np[d] = 0; m_fin[d] = 0; m_word[d] = '0; m_addr[d] = '0;
   endtask

   task automatic model_push(input int d, input logic [3:0] we);
      exp_q.push_back('{d, m_word[d], we, m_addr[d]});
      m_addr[d] = m_addr[d] + 32'd4;
      m_word[d] = '0;
      m_np[d]   = 0;
   endtask

   task automatic model_beat(input int d, input logic [15:0] data, input int nb, input logic last);
      int n;
      n = (nb > 2) ? 2 : nb;
      for (int j = 0; j < n; j++) begin
         if (!m_lim[d] || (m_count[d] < m_budget[d])) begin
            m_word[d] = m_word[d] | (32'(data[(15-8*j) -: 8]) << (24 - 8*m_np[d]));
            m_np[d]++;
            m_count[d]++;
            if (m_np[d] == 4) model_push(d, 4'hF);
         end
      end
      if (last) begin
         m_fin[d]++;
         if ((m_fin[d] == 3) && (m_np[d] > 0)) model_push(d, 4'((8'hF0 >> m_np[d])));
      end
   endtask

   // ---------------- compare process ----------------
   task automatic cmp_write(input int d, input logic [3:0] we, input logic [31:0] word,
                            input logic [31:0] addr);
      wr_t e;
      if (we != 4'h0) begin
         log_q.push_back('{d, word, we, addr});
         if ((exp_q.size() == 0) || (exp_q[0].dut != d)) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write dut%0d: got we=%b word=0x%08h, want no write",
                     d, we, word);
         end else begin
            e = exp_q.pop_front();
            check("write_word", word, e.word);
            check("write_en", 32'(we), 32'(e.we));
            check("write_addr", addr, e.addr);
         end
      end
   endtask

   always @(negedge clk_dwt) begin
      cmp_write(0, bus_a.write_en, bus_a.output_to_fpga_32, bus_a.output_address);
      cmp_write(1, bus_b.write_en, bus_b.output_to_fpga_32, bus_b.output_address);
      check("byte_count_a", byte_count_a, 32'(m_count[0]));
      check("byte_count_b", byte_count_b, 32'(m_count[1]));
      check("budget_hit_a", 32'(budget_hit_a), 32'(m_lim[0] && (m_count[0] >= m_budget[0])));
      check("budget_hit_b", 32'(budget_hit_b), 32'(m_lim[1] && (m_count[1] >= m_budget[1])));
      if (done_a) done_cnt[0]++;
      if (done_b) done_cnt[1]++;
   end

   // ---------------- stimulus helpers ----------------
   task automatic do_start(input int d, input logic [2:0] c);
      cr = c;
      sel_b = (d == 1);
      if (d == 0) start_a = 1'b1; else start_b = 1'b1;
      @(posedge clk_dwt);
      model_start(d, c);
      #1;
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   task automatic send(input int ch, input logic [15:0] data, input logic [1:0] nb,
                       input logic last);
      int t;
      in_data[ch*16 +: 16] = data;
      in_nbytes[ch*2 +: 2] = nb;
      in_last[ch]          = last;
      in_valid[ch]         = 1'b1;
      for (t = 0; t < 50; t++) begin
         @(negedge clk_dwt);
         if (watch2) check("ready2_held", 32'(rdy[2]), 32'd0);
         if (rdy[ch]) break;
      end
      if (t == 50) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout ch%0d: got in_ready=0, want 1", ch);
      end else begin
         @(posedge clk_dwt);
         model_beat(sel_b ? 1 : 0, data, int'(nb), last);
      end
      #1;
      in_valid[ch] = 1'b0;
      in_last[ch]  = 1'b0;
   endtask

   task automatic wait_done(input int d, input int prev);
      int t;
      for (t = 0; t < 20; t++) begin
         @(negedge clk_dwt);
         if (done_cnt[d] > prev) break;
      end
      repeat (3) @(negedge clk_dwt);
      check("done_once", 32'(done_cnt[d]), 32'(prev + 1));
      #1;
   endtask

   task automatic check_log(input int idx, input logic [31:0] word, input logic [3:0] we,
                            input logic [31:0] addr);
      if (idx < log_q.size()) begin
         check("log_word", log_q[idx].word, word);
         check("log_we", 32'(log_q[idx].we), 32'(we));
         check("log_addr", log_q[idx].addr, addr);
      end else begin
         n_checks++;
         n_fail++;
         $display("FAIL log_missing: got %0d writes, want entry %0d", log_q.size(), idx);
      end
   endtask

   initial begin
      int prev;
      rst = 1'b1; start_a = 1'b0; start_b = 1'b0; sel_b = 1'b0; watch2 = 1'b0; cr = '0;
      in_data = '0; in_nbytes = '0; in_valid = '0; in_last = '0;
      model_reset();
      repeat (2) @(posedge clk_dwt);
      #1 rst = 1'b0;
      check("rst_we", 32'(bus_a.write_en), 32'd0);
      check("rst_addr", bus_a.output_address, 32'd0);
      check("rst_ready", 32'(bus_a.in_ready), 32'd0);
      check("rst_done", 32'(done_a), 32'd0);

      // Basic packing with a partial flush word.
      log_q.delete(); prev = done_cnt[0];
      do_start(0, 3'd0);
      send(0, 16'h0102, 2'd2, 1'b0);
      send(0, 16'h0304, 2'd2, 1'b1);
      check("latency_we", 32'(bus_a.write_en), 32'hF);
      check("latency_word", bus_a.output_to_fpga_32, 32'h01020304);
      send(1, 16'h0506, 2'd2, 1'b1);
      send(2, 16'h0700, 2'd1, 1'b1);
      wait_done(0, prev);
      check_log(0, 32'h01020304, 4'hF, 32'd0);
      check_log(1, 32'h05060700, 4'hE, 32'd4);

      // Grant order: ch2 presents a beat early but must wait for ch0 and ch1.
      log_q.delete(); prev = done_cnt[0];
      do_start(0, 3'd0);
      in_data[32 +: 16] = 16'hC1C2; in_nbytes[4 +: 2] = 2'd2; in_last[2] = 1'b1;
      in_valid[2] = 1'b1;
      watch2 = 1'b1;
      send(0, 16'hA1A2, 2'd2, 1'b0);
      send(0, 16'hA3A4, 2'd2, 1'b1);
      send(1, 16'hB1B2, 2'd1, 1'b1);
      watch2 = 1'b0;
      send(2, 16'hC1C2, 2'd2, 1'b1);
      wait_done(0, prev);
      check_log(0, 32'hA1A2A3A4, 4'hF, 32'd0);
      check_log(1, 32'hB1C1C200, 4'hE, 32'd4);

      // Budget of 4 bytes on a 10-byte channel; excess beats still acknowledged.
      log_q.delete(); prev = done_cnt[0];
      do_start(0, 3'd7);
      send(0, 16'h1112, 2'd2, 1'b0);
      check("hit_before", 32'(budget_hit_a), 32'd0);
      send(0, 16'h1314, 2'd2, 1'b0);
      check("hit_after", 32'(budget_hit_a), 32'd1);
      send(0, 16'h1516, 2'd2, 1'b0);
      send(0, 16'h1718, 2'd2, 1'b0);
      send(0, 16'h191A, 2'd2, 1'b1);
      send(1, 16'h0000, 2'd0, 1'b1);
      send(2, 16'h0000, 2'd0, 1'b1);
      wait_done(0, prev);
      check("budget_writes", 32'(log_q.size()), 32'd1);
      check_log(0, 32'h11121314, 4'hF, 32'd0);
      check("budget_count", byte_count_a, 32'd4);
      check("budget_hit", 32'(budget_hit_a), 32'd1);

      // Budget of 6 bytes crossed in the middle of a stream.
      log_q.delete(); prev = done_cnt[1];
      do_start(1, 3'd7);
      send(0, 16'hAABB, 2'd2, 1'b0);
      send(0, 16'hCCDD, 2'd2, 1'b0);
      send(0, 16'hEEFF, 2'd2, 1'b0);
      send(0, 16'h1122, 2'd2, 1'b1);
      send(1, 16'h0000, 2'd0, 1'b1);
      send(2, 16'h0000, 2'd0, 1'b1);
      wait_done(1, prev);
      check_log(0, 32'hAABBCCDD, 4'hF, 32'd0);
      check_log(1, 32'hEEFF0000, 4'hC, 32'd4);
      check("cross_count", byte_count_b, 32'd6);

      // Reset mid-stream after three words, with two bytes still pending.
      log_q.delete();
      do_start(0, 3'd0);
      for (int i = 0; i < 7; i++) send(0, 16'(16'h2000 + 16'(i)), 2'd2, 1'b0);
      check("pre_rst_writes", 32'(log_q.size()), 32'd3);
      rst = 1'b1;
      @(posedge clk_dwt);
      model_reset();
      #1 rst = 1'b0;
      check("post_rst_we", 32'(bus_a.write_en), 32'd0);
      check("post_rst_addr", bus_a.output_address, 32'd0);
      check("post_rst_count", byte_count_a, 32'd0);
      repeat (5) @(posedge clk_dwt);
      #1;
      check("no_flush_after_rst", 32'(log_q.size()), 32'd3);
      log_q.delete(); prev = done_cnt[0];
      do_start(0, 3'd0);
      send(0, 16'hDEAD, 2'd3, 1'b1);
      send(1, 16'h0000, 2'd0, 1'b1);
      send(2, 16'h0000, 2'd0, 1'b1);
      wait_done(0, prev);
      check_log(0, 32'hDEAD0000, 4'hC, 32'd0);

      // Empty stream.
      log_q.delete(); prev = done_cnt[0];
      do_start(0, 3'd0);
      for (int c = 0; c < 3; c++) send(c, 16'hFFFF, 2'd0, 1'b1);
      wait_done(0, prev);
      check("empty_writes", 32'(log_q.size()), 32'd0);
      check("empty_count", byte_count_a, 32'd0);

      check("leftover_expected", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
